// File: rtl/cbd_poly_collect_pkg.sv
// Shared constants and state encoding for the CBD polynomial collector.
// Kyber modulus, polynomial geometry and beat widths live here.
package cbd_poly_collect_pkg;

    localparam int KYBER_Q = 3329;
    localparam int KYBER_N = 256;
    localparam int COEFF_W = 12;
    localparam int CBD_W   = 3;

    localparam int N_IN    = 16;
    localparam int N_OUT   = 4;
    localparam int IN_W    = N_IN * CBD_W;
    localparam int OUT_W   = N_OUT * COEFF_W;
    localparam int ROW_W   = N_IN * COEFF_W;
    localparam int N_ROWS  = KYBER_N / N_IN;
    localparam int N_BEATS = KYBER_N / N_OUT;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/cbd_poly_collect_coeff_modq.sv
// Maps one 3-bit two's-complement CBD sample to its canonical value mod q.
// Negative samples land just below q, so q-8+s never leaves 12 bits.
module cbd_coeff_modq
    import cbd_poly_collect_pkg::*;
(
    input  logic [CBD_W-1:0]   sample,
    output logic [COEFF_W-1:0] coeff
);

    localparam logic [COEFF_W-1:0] Q_MINUS_8 = COEFF_W'(KYBER_Q - 8);

    assign coeff = sample[CBD_W-1] ? (Q_MINUS_8 + {9'b0, sample})
                                   : {9'b0, sample};

endmodule

// File: rtl/cbd_poly_collect.sv
// Collects 16 beats of CBD samples into one mod-q polynomial buffer,
// then streams it out 4 coefficients per beat.
module cbd_poly_collect
    import cbd_poly_collect_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [IN_W-1:0]   i_coeffs,
    input  logic              i_coeffs_valid,
    output logic              o_ready,
    output logic [OUT_W-1:0]  o_poly,
    output logic              o_poly_valid,
    input  logic              i_poly_ready,
    output logic              o_poly_last,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_dbg_state
);

    // Output handshake: a beat transfers on a rising edge where o_poly_valid &&
    // i_poly_ready; valid stays high and o_poly/o_poly_last hold until then.
    // The input side has no backpressure: every i_coeffs_valid is a beat, and
    // o_ready only advertises whether such a beat will be stored.

    state_t           state;
    logic [3:0]       wr_cnt;
    logic [5:0]       rd_cnt;
    logic [5:0]       rd_nxt;
    logic             wr_en;
    logic [ROW_W-1:0] wr_row;
    logic [ROW_W-1:0] buf_mem [N_ROWS];
    logic [OUT_W-1:0] first_beat;
    logic [OUT_W-1:0] nxt_beat;

    function automatic logic [OUT_W-1:0] beat_of(input logic [ROW_W-1:0] row,
                                                 input logic [1:0] q);
        return row[ROW_W-1-OUT_W*int'(q) -: OUT_W];
    endfunction

    for (genvar j = 0; j < N_IN; j++) begin : g_map
        cbd_coeff_modq u_map (
            .sample (i_coeffs[IN_W-1-CBD_W*j -: CBD_W]),
            .coeff  (wr_row[ROW_W-1-COEFF_W*j -: COEFF_W])
        );
    end

    assign wr_en       = i_coeffs_valid && (state == S_IDLE || state == S_FILL);
    assign o_ready     = (state == S_IDLE) || (state == S_FILL);
    assign o_dbg_state = state;
    assign rd_nxt      = rd_cnt + 6'd1;
    assign first_beat  = beat_of(buf_mem[0], 2'd0);
    assign nxt_beat    = beat_of(buf_mem[rd_nxt[5:2]], rd_nxt[1:0]);

    // Buffer is plain storage with no reset; contents are only read after a full fill.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            buf_mem[wr_cnt] <= wr_row;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state        <= S_IDLE;
            wr_cnt       <= 4'd0;
            rd_cnt       <= 6'd0;
            o_poly       <= '0;
            o_poly_valid <= 1'b0;
            o_poly_last  <= 1'b0;
            o_done       <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_coeffs_valid) begin
                        wr_cnt <= 4'd1;
                        state  <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (i_coeffs_valid) begin
                        if (wr_cnt == 4'd15) begin
                            wr_cnt       <= 4'd0;
                            rd_cnt       <= 6'd0;
                            o_poly       <= first_beat;
                            o_poly_valid <= 1'b1;
                            o_poly_last  <= 1'b0;
                            state        <= S_DRAIN;
                        end else begin
                            wr_cnt <= wr_cnt + 4'd1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (i_coeffs_valid) begin
                        o_err <= 1'b1;
                    end
                    if (i_poly_ready) begin
                        if (rd_cnt == 6'd63) begin
                            rd_cnt       <= 6'd0;
                            o_poly       <= '0;
                            o_poly_valid <= 1'b0;
                            o_poly_last  <= 1'b0;
                            o_done       <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            rd_cnt      <= rd_nxt;
                            o_poly      <= nxt_beat;
                            o_poly_last <= (rd_nxt == 6'd63);
                        end
                    end
                end
                S_DONE: begin
                    if (i_coeffs_valid) begin
                        o_err <= 1'b1;
                    end
                    wr_cnt <= 4'd0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cbd_poly_collect.sv
// Directed bench for cbd_poly_collect: fill, drain, backpressure, overflow
// and reset-mid-drain scenarios with hand-derived expectations.
module tb_cbd_poly_collect;

    logic        i_clk = 1'b0;
    logic        i_rstn;
    logic [47:0] i_coeffs;
    logic        i_coeffs_valid;
    logic        o_ready;
    logic [47:0] o_poly;
    logic        o_poly_valid;
    logic        i_poly_ready;
    logic        o_poly_last;
    logic        o_done;
    logic        o_err;
    logic [1:0]  o_dbg_state;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [47:0] in_beats [16];
    logic [47:0] exp_q [$];
    logic [47:0] got_poly [64];
    logic        got_last [64];

    int   drained, stall_viol, ready_high_seen, done_early, fill_ready_low;
    logic valid_before_last, valid_after_last, done_after1, done_after2;

    // ---------------- clock / reset ----------------
    always #5 i_clk = ~i_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    cbd_poly_collect dut (
        .i_clk          (i_clk),
        .i_rstn         (i_rstn),
        .i_coeffs       (i_coeffs),
        .i_coeffs_valid (i_coeffs_valid),
        .o_ready        (o_ready),
        .o_poly         (o_poly),
        .o_poly_valid   (o_poly_valid),
        .i_poly_ready   (i_poly_ready),
        .o_poly_last    (o_poly_last),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_dbg_state    (o_dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic logic [11:0] map_ref(input logic [2:0] s);
        int v;
        v = s[2] ? int'(s) - 8 : int'(s);
        if (v < 0) v = v + 3329;
        return 12'(v);
    endfunction

    task automatic build_exp();
        logic [11:0] c [256];
        exp_q.delete();
        for (int k = 0; k < 16; k++)
            for (int j = 0; j < 16; j++)
                c[16*k+j] = map_ref(in_beats[k][47-3*j -: 3]);
        for (int b = 0; b < 64; b++)
            exp_q.push_back({c[4*b], c[4*b+1], c[4*b+2], c[4*b+3]});
    endtask

    // ---------------- drivers ----------------
    task automatic send_poly(input int gap);
        i_poly_ready   = 1'b0;
        fill_ready_low = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge i_clk);
            if (!o_ready) fill_ready_low++;
            if (k == 15) valid_before_last = o_poly_valid;
            i_coeffs       = in_beats[k];
            i_coeffs_valid = 1'b1;
            if (k < 15) begin
                repeat (gap) begin
                    @(negedge i_clk);
                    i_coeffs_valid = 1'b0;
                    i_coeffs       = 48'hFFFF_FFFF_FFFF;
                end
            end
        end
        @(negedge i_clk);
        i_coeffs_valid   = 1'b0;
        valid_after_last = o_poly_valid;
    endtask

    // Captures handshaked beats; optionally injects an overflow beat at handshake
    // inject_at and stops after stop_at handshakes.
    task automatic drain_poly(input int rand_ready, input int inject_at, input int stop_at);
        int          hs = 0;
        int          cyc = 0;
        logic        rdy;
        logic        prev_stall = 1'b0;
        logic        prev_last = 1'b0;
        logic        injected = 1'b0;
        logic [47:0] prev_poly = '0;
        stall_viol      = 0;
        ready_high_seen = 0;
        done_early      = 0;
        while (hs < stop_at && cyc < 2000) begin
            @(negedge i_clk);
            cyc++;
            i_coeffs_valid = 1'b0;
            if (o_done)  done_early++;
            if (o_ready) ready_high_seen++;
            if (prev_stall && (o_poly !== prev_poly || o_poly_last !== prev_last || o_poly_valid !== 1'b1))
                stall_viol++;
            rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            i_poly_ready = rdy;
            if (hs == inject_at && !injected) begin
                i_coeffs       = 48'hDB6D_B6DB_6DB6;
                i_coeffs_valid = 1'b1;
                injected       = 1'b1;
            end
            if (o_poly_valid && rdy) begin
                got_poly[hs] = o_poly;
                got_last[hs] = o_poly_last;
                hs++;
            end
            prev_stall = o_poly_valid && !rdy;
            prev_poly  = o_poly;
            prev_last  = o_poly_last;
        end
        drained = hs;
        if (stop_at == 64) begin
            @(negedge i_clk);
            i_poly_ready   = 1'b0;
            i_coeffs_valid = 1'b0;
            done_after1    = o_done;
            @(negedge i_clk);
            done_after2    = o_done;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rstn = 1'b0; i_coeffs = '0; i_coeffs_valid = 1'b0; i_poly_ready = 1'b0;
        #1;
        tests_run++; if (o_poly !== 48'd0)     begin tests_failed++; $display("FAIL reset_poly got=%h exp=0", o_poly); end
        tests_run++; if (o_poly_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got=%b exp=0", o_poly_valid); end
        tests_run++; if (o_poly_last !== 1'b0)  begin tests_failed++; $display("FAIL reset_last got=%b exp=0", o_poly_last); end
        tests_run++; if (o_done !== 1'b0)       begin tests_failed++; $display("FAIL reset_done got=%b exp=0", o_done); end
        tests_run++; if (o_err !== 1'b0)        begin tests_failed++; $display("FAIL reset_err got=%b exp=0", o_err); end
        tests_run++; if (o_ready !== 1'b1)      begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        tests_run++; if (o_dbg_state !== 2'd0)  begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", o_dbg_state); end
        repeat (2) @(negedge i_clk);
        i_rstn = 1'b1;
    endtask

    task automatic test_zero_poly();
        for (int k = 0; k < 16; k++) in_beats[k] = '0;
        send_poly(0);
        drain_poly(0, -1, 64);
        tests_run++; if (drained != 64) begin tests_failed++; $display("FAIL zero_count got=%0d exp=64", drained); end
        for (int b = 0; b < drained; b++) begin
            tests_run++; if (got_poly[b] !== 48'd0) begin tests_failed++; $display("FAIL zero_data beat=%0d got=%h exp=0", b, got_poly[b]); end
            tests_run++; if (got_last[b] !== (b == 63)) begin tests_failed++; $display("FAIL zero_last beat=%0d got=%b exp=%b", b, got_last[b], b == 63); end
        end
        tests_run++; if (done_early != 0)    begin tests_failed++; $display("FAIL zero_done_early got=%0d exp=0", done_early); end
        tests_run++; if (done_after1 !== 1'b1) begin tests_failed++; $display("FAIL zero_done_pulse got=%b exp=1", done_after1); end
        tests_run++; if (done_after2 !== 1'b0) begin tests_failed++; $display("FAIL zero_done_width got=%b exp=0", done_after2); end
        tests_run++; if (o_err !== 1'b0)     begin tests_failed++; $display("FAIL zero_err got=%b exp=0", o_err); end
        tests_run++; if (ready_high_seen != 0) begin tests_failed++; $display("FAIL zero_ready_in_drain got=%0d exp=0", ready_high_seen); end
        tests_run++; if (o_dbg_state !== 2'd0) begin tests_failed++; $display("FAIL zero_back_idle got=%0d exp=0", o_dbg_state); end
    endtask

    task automatic test_sign_mapping();
        for (int k = 0; k < 16; k++) in_beats[k] = '0;
        in_beats[0] = {3'b001, 3'b010, 3'b011, 3'b111, 3'b110, 3'b101, 3'b100, 3'b000, 24'd0};
        send_poly(0);
        drain_poly(0, -1, 64);
        tests_run++; if (drained != 64) begin tests_failed++; $display("FAIL sign_count got=%0d exp=64", drained); end
        tests_run++; if (got_poly[0] !== {12'd1, 12'd2, 12'd3, 12'd3328})
            begin tests_failed++; $display("FAIL sign_beat0 got=%h exp=%h", got_poly[0], {12'd1, 12'd2, 12'd3, 12'd3328}); end
        tests_run++; if (got_poly[1] !== {12'd3327, 12'd3326, 12'd3325, 12'd0})
            begin tests_failed++; $display("FAIL sign_beat1 got=%h exp=%h", got_poly[1], {12'd3327, 12'd3326, 12'd3325, 12'd0}); end
        for (int b = 2; b < 64; b++) begin
            tests_run++; if (got_poly[b] !== 48'd0) begin tests_failed++; $display("FAIL sign_rest beat=%0d got=%h exp=0", b, got_poly[b]); end
        end
    endtask

    task automatic test_index_order();
        logic [11:0] v;
        for (int k = 0; k < 16; k++) in_beats[k] = {16{3'(k % 4)}};
        send_poly(0);
        tests_run++; if (fill_ready_low != 0)     begin tests_failed++; $display("FAIL idx_ready_fill got=%0d exp=0", fill_ready_low); end
        tests_run++; if (valid_before_last !== 1'b0) begin tests_failed++; $display("FAIL idx_valid_early got=%b exp=0", valid_before_last); end
        tests_run++; if (valid_after_last !== 1'b1)  begin tests_failed++; $display("FAIL idx_first_latency got=%b exp=1", valid_after_last); end
        drain_poly(0, -1, 64);
        tests_run++; if (drained != 64) begin tests_failed++; $display("FAIL idx_count got=%0d exp=64", drained); end
        for (int b = 0; b < drained; b++) begin
            v = 12'((b / 4) % 4);
            tests_run++; if (got_poly[b] !== {v, v, v, v}) begin tests_failed++; $display("FAIL idx_data beat=%0d got=%h exp=%h", b, got_poly[b], {v, v, v, v}); end
        end
    endtask

    task automatic test_backpressure();
        logic [47:0] e;
        for (int k = 0; k < 16; k++) in_beats[k] = {$urandom(), 16'($urandom())};
        build_exp();
        send_poly(1);
        tests_run++; if (valid_after_last !== 1'b1) begin tests_failed++; $display("FAIL bp_first_latency got=%b exp=1", valid_after_last); end
        drain_poly(1, -1, 64);
        tests_run++; if (drained != 64)  begin tests_failed++; $display("FAIL bp_count got=%0d exp=64", drained); end
        tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL bp_stall_stable got=%0d exp=0", stall_viol); end
        for (int b = 0; b < drained; b++) begin
            e = exp_q.pop_front();
            tests_run++; if (got_poly[b] !== e) begin tests_failed++; $display("FAIL bp_data beat=%0d got=%h exp=%h", b, got_poly[b], e); end
            tests_run++; if (got_last[b] !== (b == 63)) begin tests_failed++; $display("FAIL bp_last beat=%0d got=%b exp=%b", b, got_last[b], b == 63); end
        end
        tests_run++; if (done_after1 !== 1'b1) begin tests_failed++; $display("FAIL bp_done_pulse got=%b exp=1", done_after1); end
    endtask

    task automatic test_overflow();
        logic [47:0] e;
        for (int k = 0; k < 16; k++) in_beats[k] = {16{3'(7 - (k % 8))}} ^ {44'd0, 4'(k)};
        build_exp();
        send_poly(0);
        drain_poly(0, 10, 64);
        tests_run++; if (drained != 64)       begin tests_failed++; $display("FAIL ovf_count got=%0d exp=64", drained); end
        tests_run++; if (ready_high_seen != 0) begin tests_failed++; $display("FAIL ovf_ready got=%0d exp=0", ready_high_seen); end
        for (int b = 0; b < drained; b++) begin
            e = exp_q.pop_front();
            tests_run++; if (got_poly[b] !== e) begin tests_failed++; $display("FAIL ovf_data beat=%0d got=%h exp=%h", b, got_poly[b], e); end
        end
        tests_run++; if (done_after1 !== 1'b1) begin tests_failed++; $display("FAIL ovf_done got=%b exp=1", done_after1); end
        tests_run++; if (o_err !== 1'b1)       begin tests_failed++; $display("FAIL ovf_err got=%b exp=1", o_err); end
        repeat (3) @(negedge i_clk);
        tests_run++; if (o_err !== 1'b1)       begin tests_failed++; $display("FAIL ovf_err_sticky got=%b exp=1", o_err); end
        tests_run++; if (o_dbg_state !== 2'd0) begin tests_failed++; $display("FAIL ovf_idle got=%0d exp=0", o_dbg_state); end
    endtask

    task automatic test_reset_mid_drain();
        logic [47:0] e;
        int          done_seen = 0;
        for (int k = 0; k < 16; k++) in_beats[k] = {16{3'b101}};
        send_poly(0);
        drain_poly(0, -1, 20);
        @(negedge i_clk);
        i_poly_ready = 1'b0;
        i_rstn       = 1'b0;
        #1;
        tests_run++; if (o_poly_valid !== 1'b0) begin tests_failed++; $display("FAIL rmd_valid got=%b exp=0", o_poly_valid); end
        tests_run++; if (o_poly !== 48'd0)     begin tests_failed++; $display("FAIL rmd_poly got=%h exp=0", o_poly); end
        tests_run++; if (o_poly_last !== 1'b0)  begin tests_failed++; $display("FAIL rmd_last got=%b exp=0", o_poly_last); end
        tests_run++; if (o_err !== 1'b0)        begin tests_failed++; $display("FAIL rmd_err got=%b exp=0", o_err); end
        tests_run++; if (o_ready !== 1'b1)      begin tests_failed++; $display("FAIL rmd_ready got=%b exp=1", o_ready); end
        tests_run++; if (o_dbg_state !== 2'd0)  begin tests_failed++; $display("FAIL rmd_state got=%0d exp=0", o_dbg_state); end
        repeat (2) begin @(negedge i_clk); if (o_done) done_seen++; end
        i_rstn = 1'b1;
        repeat (3) begin @(negedge i_clk); if (o_done) done_seen++; end
        tests_run++; if (done_seen != 0) begin tests_failed++; $display("FAIL rmd_no_done got=%0d exp=0", done_seen); end
        for (int k = 0; k < 16; k++) in_beats[k] = {16{3'(k % 8)}};
        build_exp();
        send_poly(0);
        drain_poly(0, -1, 64);
        tests_run++; if (drained != 64) begin tests_failed++; $display("FAIL rmd_refill_count got=%0d exp=64", drained); end
        for (int b = 0; b < drained; b++) begin
            e = exp_q.pop_front();
            tests_run++; if (got_poly[b] !== e) begin tests_failed++; $display("FAIL rmd_refill_data beat=%0d got=%h exp=%h", b, got_poly[b], e); end
        end
        tests_run++; if (done_after1 !== 1'b1) begin tests_failed++; $display("FAIL rmd_refill_done got=%b exp=1", done_after1); end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_zero_poly();
        test_sign_mapping();
        test_index_order();
        test_backpressure();
        test_overflow();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
